// File: rtl/cpu_pkg.sv
// Shared CPU types and constants.
// Holds the memory-arbiter FSM states, the port identifiers used for
// ownership and round-robin history, and bus width constants.
package cpu_pkg;

  localparam int unsigned ADDR_W    = 32;
  localparam int unsigned DATA_W    = 32;
  localparam int unsigned WE_W      = 4;
  localparam int unsigned LAT_CNT_W = 2;

  localparam logic [WE_W-1:0] MEM_WE_NONE = 4'b0000;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } e_arb_state;

  typedef enum logic {
    INST = 1'b0,
    DATA = 1'b1
  } e_port;

endpackage

// File: rtl/cpu_rr_pick.sv
// Two-way round-robin / fixed-priority request picker (combinational).
// Ports:
//   req_i        [0] = inst request, [1] = data request
//   last_grant_i port granted most recently (INST/DATA encoding)
//   prio_i       1 = data wins every tie, 0 = alternate on ties
//   any_c_o      at least one request present
//   winner_c_o   selected port (INST/DATA encoding)
module cpu_rr_pick
  import cpu_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_grant_i,
  input  logic       prio_i,
  output logic       any_c_o,
  output logic       winner_c_o
);

  // On a tie, hand the grant to whichever port did not win last time.
  always_comb begin
    any_c_o    = |req_i;
    winner_c_o = INST;
    case (req_i)
      2'b01:   winner_c_o = INST;
      2'b10:   winner_c_o = DATA;
      2'b11:   winner_c_o = (prio_i || (last_grant_i == INST)) ? DATA : INST;
      default: winner_c_o = INST;
    endcase
  end

endmodule

// File: rtl/cpu_mem_arbiter.sv
// Shares one single-ported synchronous memory between the CPU instruction
// and data ports, one transaction at a time, absorbing the read latency.
// Ports:
//   aclk, aresetn              clock, synchronous active-low reset
//   inst_* / data_*            req/addr/wdata/we in; gnt/rvalid/rdata out
//   mem_en, mem_we, mem_addr   memory command (word address)
//   mem_wdata, mem_rdata       memory write / read data
module cpu_mem_arbiter
  import cpu_pkg::*;
#(
  parameter int unsigned READ_LATENCY = 1,
  parameter bit          PRIO_DATA    = 1'b0
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  input  logic [3:0]  inst_we,
  output logic        inst_gnt,
  output logic        inst_rvalid,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  input  logic [3:0]  data_we,
  output logic        data_gnt,
  output logic        data_rvalid,
  output logic [31:0] data_rdata,
  output logic        mem_en,
  output logic [3:0]  mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_latency
    $error("cpu_mem_arbiter: READ_LATENCY=%0d is outside 1..4", READ_LATENCY);
  end

  e_arb_state          state_q, state_d;
  e_port               owner_q, owner_d;
  e_port               last_grant_q, last_grant_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [WE_W-1:0]     we_q, we_d;
  logic [LAT_CNT_W-1:0] cnt_q, cnt_d;
  logic                capture;

  logic                inst_gnt_q, inst_gnt_d, data_gnt_q, data_gnt_d;
  logic                inst_rvalid_q, inst_rvalid_d, data_rvalid_q, data_rvalid_d;
  logic [DATA_W-1:0]   inst_rdata_q, inst_rdata_d, data_rdata_q, data_rdata_d;
  logic                mem_en_q, mem_en_d;
  logic [WE_W-1:0]     mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;

  logic                pick_any;
  logic                pick_winner;

  // Byte-lane bits are not part of the word address; lanes are chosen via we.
  logic unused_byte_lane;
  assign unused_byte_lane = ^{inst_addr[1:0], data_addr[1:0]};

  cpu_rr_pick u_pick (
    .req_i        ({data_req, inst_req}),
    .last_grant_i (last_grant_q),
    .prio_i       (PRIO_DATA),
    .any_c_o      (pick_any),
    .winner_c_o   (pick_winner)
  );

  // State and latched-request registers.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q      <= IDLE;
      owner_q      <= INST;
      last_grant_q <= DATA;
      addr_q       <= '0;
      wdata_q      <= '0;
      we_q         <= MEM_WE_NONE;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      we_q         <= we_d;
      cnt_q        <= cnt_d;
    end
  end

  // Next-state: arbitrate in IDLE, count out the read latency in WAIT.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    we_d         = we_q;
    cnt_d        = cnt_q;
    capture      = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d      = ISSUE;
          owner_d      = e_port'(pick_winner);
          last_grant_d = e_port'(pick_winner);
          if (pick_winner == DATA) begin
            addr_d  = {2'b00, data_addr[ADDR_W-1:2]};
            wdata_d = data_wdata;
            we_d    = data_we;
          end else begin
            addr_d  = {2'b00, inst_addr[ADDR_W-1:2]};
            wdata_d = inst_wdata;
            we_d    = inst_we;
          end
        end
      end
      ISSUE: begin
        cnt_d   = LAT_CNT_W'(READ_LATENCY - 1);
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q == '0) begin
          capture = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - LAT_CNT_W'(1);
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they appear registered.
  always_comb begin
    mem_en_d      = (state_d == ISSUE);
    mem_we_d      = (state_d == ISSUE) ? we_d : MEM_WE_NONE;
    mem_addr_d    = addr_d;
    mem_wdata_d   = wdata_d;
    inst_gnt_d    = (state_d == ISSUE) && (owner_d == INST);
    data_gnt_d    = (state_d == ISSUE) && (owner_d == DATA);
    inst_rvalid_d = (state_d == RESP) && (owner_d == INST);
    data_rvalid_d = (state_d == RESP) && (owner_d == DATA);
    inst_rdata_d  = inst_rdata_q;
    data_rdata_d  = data_rdata_q;
    if (capture) begin
      if (owner_q == INST) inst_rdata_d = mem_rdata;
      else                 data_rdata_d = mem_rdata;
    end
  end

  // Output registers.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      mem_en_q      <= 1'b0;
      mem_we_q      <= MEM_WE_NONE;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      inst_gnt_q    <= 1'b0;
      data_gnt_q    <= 1'b0;
      inst_rvalid_q <= 1'b0;
      data_rvalid_q <= 1'b0;
      inst_rdata_q  <= '0;
      data_rdata_q  <= '0;
    end else begin
      mem_en_q      <= mem_en_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      inst_gnt_q    <= inst_gnt_d;
      data_gnt_q    <= data_gnt_d;
      inst_rvalid_q <= inst_rvalid_d;
      data_rvalid_q <= data_rvalid_d;
      inst_rdata_q  <= inst_rdata_d;
      data_rdata_q  <= data_rdata_d;
    end
  end

  assign mem_en      = mem_en_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign inst_gnt    = inst_gnt_q;
  assign data_gnt    = data_gnt_q;
  assign inst_rvalid = inst_rvalid_q;
  assign data_rvalid = data_rvalid_q;
  assign inst_rdata  = inst_rdata_q;
  assign data_rdata  = data_rdata_q;

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// Bench for cpu_mem_arbiter. Three instances share clock and reset:
//   dut0: READ_LATENCY=1, round-robin
//   dut1: READ_LATENCY=1, data priority
//   dut2: READ_LATENCY=3, round-robin
// Each instance drives its own BRAM model. Expected completions are queued
// when a request is driven and checked when an rvalid pulse appears.
module tb_cpu_mem_arbiter;

  localparam int NI     = 3;
  localparam bit P_INST = 1'b0;
  localparam bit P_DATA = 1'b1;

  logic aclk;
  logic aresetn;
  logic preload;

  logic        inst_req    [NI];
  logic [31:0] inst_addr   [NI];
  logic [31:0] inst_wdata  [NI];
  logic [3:0]  inst_we     [NI];
  logic        inst_gnt    [NI];
  logic        inst_rvalid [NI];
  logic [31:0] inst_rdata  [NI];
  logic        data_req    [NI];
  logic [31:0] data_addr   [NI];
  logic [31:0] data_wdata  [NI];
  logic [3:0]  data_we     [NI];
  logic        data_gnt    [NI];
  logic        data_rvalid [NI];
  logic [31:0] data_rdata  [NI];
  logic        mem_en      [NI];
  logic [3:0]  mem_we      [NI];
  logic [31:0] mem_addr    [NI];
  logic [31:0] mem_wdata   [NI];
  logic [31:0] mem_rdata   [NI];

  typedef struct {
    int          k;
    bit          port;
    logic [31:0] data;
    bit          chk_data;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;

  function automatic logic [31:0] mem_init(input int i);
    return (i == 4) ? 32'hDEADBEEF : (32'hC0DE_0000 | 32'(i));
  endfunction

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int unsigned RL = (g == 2) ? 3 : 1;
    localparam bit          PD = (g == 1);

    logic [31:0] mem  [256];
    logic [31:0] pipe [4];

    cpu_mem_arbiter #(.READ_LATENCY(RL), .PRIO_DATA(PD)) u_dut (
      .aclk        (aclk),
      .aresetn     (aresetn),
      .inst_req    (inst_req[g]),
      .inst_addr   (inst_addr[g]),
      .inst_wdata  (inst_wdata[g]),
      .inst_we     (inst_we[g]),
      .inst_gnt    (inst_gnt[g]),
      .inst_rvalid (inst_rvalid[g]),
      .inst_rdata  (inst_rdata[g]),
      .data_req    (data_req[g]),
      .data_addr   (data_addr[g]),
      .data_wdata  (data_wdata[g]),
      .data_we     (data_we[g]),
      .data_gnt    (data_gnt[g]),
      .data_rvalid (data_rvalid[g]),
      .data_rdata  (data_rdata[g]),
      .mem_en      (mem_en[g]),
      .mem_we      (mem_we[g]),
      .mem_addr    (mem_addr[g]),
      .mem_wdata   (mem_wdata[g]),
      .mem_rdata   (mem_rdata[g])
    );

    // BRAM model: read-before-write, RL-cycle read pipeline.
    always @(posedge aclk) begin
      if (preload) begin
        for (int i = 0; i < 256; i++) mem[i] <= mem_init(i);
      end else if (mem_en[g]) begin
        pipe[0] <= mem[mem_addr[g][7:0]];
        for (int b = 0; b < 4; b++)
          if (mem_we[g][b]) mem[mem_addr[g][7:0]][8*b +: 8] <= mem_wdata[g][8*b +: 8];
      end
      for (int s = 1; s < 4; s++) pipe[s] <= pipe[s-1];
    end

    assign mem_rdata[g] = pipe[RL-1];
  end

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%08h expected=%08h", tag, obs, expv);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, expv);
    end
  endtask

  task automatic push(input int k, input bit port, input logic [31:0] d, input bit cd);
    exp_t e;
    e.k        = k;
    e.port     = port;
    e.data     = d;
    e.chk_data = cd;
    sb_q.push_back(e);
  endtask

  task automatic sb_pop(input int k, input bit port, input logic [31:0] rd);
    exp_t e;
    total++;
    assert (sb_q.size() != 0) else begin
      bad++;
      $error("FAIL sb_unexpected_rvalid: observed rvalid dut%0d port%0d, expected none", k, port);
    end
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      chk32("sb_dut", 32'(k), 32'(e.k));
      chk1("sb_port", port, e.port);
      if (e.chk_data) chk32("sb_rdata", rd, e.data);
    end
  endtask

  // Advance to the next falling edge and score any completions.
  task automatic tick();
    @(negedge aclk);
    for (int k = 0; k < NI; k++) begin
      if (inst_rvalid[k]) sb_pop(k, P_INST, inst_rdata[k]);
      if (data_rvalid[k]) sb_pop(k, P_DATA, data_rdata[k]);
    end
  endtask

  task automatic chk_zero(input int k, input string tag);
    chk1({tag, "_inst_gnt"},    inst_gnt[k],    1'b0);
    chk1({tag, "_data_gnt"},    data_gnt[k],    1'b0);
    chk1({tag, "_inst_rvalid"}, inst_rvalid[k], 1'b0);
    chk1({tag, "_data_rvalid"}, data_rvalid[k], 1'b0);
    chk1({tag, "_mem_en"},      mem_en[k],      1'b0);
    chk32({tag, "_mem_we"},     32'(mem_we[k]), 32'h0);
    chk32({tag, "_mem_addr"},   mem_addr[k],    32'h0);
    chk32({tag, "_mem_wdata"},  mem_wdata[k],   32'h0);
    chk32({tag, "_inst_rdata"}, inst_rdata[k],  32'h0);
    chk32({tag, "_data_rdata"}, data_rdata[k],  32'h0);
  endtask

  initial begin
    aresetn = 1'b0;
    preload = 1'b1;
    for (int k = 0; k < NI; k++) begin
      inst_req[k] = 1'b0; inst_addr[k] = '0; inst_wdata[k] = '0; inst_we[k] = '0;
      data_req[k] = 1'b0; data_addr[k] = '0; data_wdata[k] = '0; data_we[k] = '0;
    end

    // Reset state
    tick();
    tick();
    preload = 1'b0;
    for (int k = 0; k < NI; k++) chk_zero(k, $sformatf("rst%0d", k));
    aresetn = 1'b1;
    tick();

    // Single inst read of 0x10 (dut0)
    inst_addr[0] = 32'h10;
    inst_req[0]  = 1'b1;
    push(0, P_INST, 32'hDEADBEEF, 1'b1);
    tick();
    chk1("t1_inst_gnt", inst_gnt[0], 1'b1);
    chk1("t1_data_gnt", data_gnt[0], 1'b0);
    chk1("t1_mem_en",   mem_en[0],   1'b1);
    chk32("t1_mem_addr", mem_addr[0], 32'h4);
    chk32("t1_mem_we",   32'(mem_we[0]), 32'h0);
    inst_req[0] = 1'b0;
    tick();
    chk1("t1_wait_mem_en", mem_en[0], 1'b0);
    chk1("t1_wait_rvalid", inst_rvalid[0], 1'b0);
    tick();
    chk1("t1_inst_rvalid", inst_rvalid[0], 1'b1);
    chk32("t1_inst_rdata", inst_rdata[0], 32'hDEADBEEF);
    chk1("t1_data_rvalid", data_rvalid[0], 1'b0);
    tick();

    // Data word write to 0x20, then inst read-back (dut0)
    data_addr[0]  = 32'h20;
    data_we[0]    = 4'hF;
    data_wdata[0] = 32'h12345678;
    data_req[0]   = 1'b1;
    push(0, P_DATA, 32'h0, 1'b0);
    tick();
    chk1("t2_data_gnt", data_gnt[0], 1'b1);
    chk1("t2_inst_gnt", inst_gnt[0], 1'b0);
    chk32("t2_mem_we",    32'(mem_we[0]), 32'hF);
    chk32("t2_mem_addr",  mem_addr[0],  32'h8);
    chk32("t2_mem_wdata", mem_wdata[0], 32'h12345678);
    data_req[0] = 1'b0;
    data_we[0]  = 4'h0;
    tick();
    chk32("t2_wait_mem_we", 32'(mem_we[0]), 32'h0);
    tick();
    chk1("t2_data_rvalid", data_rvalid[0], 1'b1);
    chk1("t2_inst_rvalid", inst_rvalid[0], 1'b0);
    chk32("t2_inst_rdata_hold", inst_rdata[0], 32'hDEADBEEF);
    tick();
    inst_addr[0] = 32'h20;
    inst_req[0]  = 1'b1;
    push(0, P_INST, 32'h12345678, 1'b1);
    tick();
    chk1("t2_rb_gnt", inst_gnt[0], 1'b1);
    chk32("t2_rb_mem_addr", mem_addr[0], 32'h8);
    inst_req[0] = 1'b0;
    tick();
    tick();
    chk32("t2_rb_rdata", inst_rdata[0], 32'h12345678);
    tick();

    // Round-robin tie after reset: inst, data, inst, data (dut0)
    aresetn = 1'b0;
    tick();
    aresetn = 1'b1;
    inst_addr[0] = 32'h40;
    data_addr[0] = 32'h44;
    inst_req[0]  = 1'b1;
    data_req[0]  = 1'b1;
    for (int i = 0; i < 2; i++) begin
      push(0, P_INST, mem_init(16), 1'b1);
      push(0, P_DATA, mem_init(17), 1'b1);
    end
    for (int t = 0; t < 16; t++) begin
      tick();
      chk1($sformatf("t3_inst_gnt_%0d", t), inst_gnt[0], (t % 4 == 0) && ((t / 4) % 2 == 0));
      chk1($sformatf("t3_data_gnt_%0d", t), data_gnt[0], (t % 4 == 0) && ((t / 4) % 2 == 1));
    end
    inst_req[0] = 1'b0;
    data_req[0] = 1'b0;
    tick();
    chk1("t3_idle_mem_en", mem_en[0], 1'b0);

    // Data priority tie: inst starved until data_req drops (dut1)
    inst_addr[1] = 32'h50;
    data_addr[1] = 32'h54;
    inst_req[1]  = 1'b1;
    data_req[1]  = 1'b1;
    for (int i = 0; i < 3; i++) push(1, P_DATA, mem_init(21), 1'b1);
    push(1, P_INST, mem_init(20), 1'b1);
    for (int t = 0; t < 13; t++) begin
      tick();
      chk1($sformatf("t4_data_gnt_%0d", t), data_gnt[1], (t % 4 == 0) && (t < 12));
      chk1($sformatf("t4_inst_gnt_%0d", t), inst_gnt[1], t == 12);
      if (t == 11) data_req[1] = 1'b0;
    end
    inst_req[1] = 1'b0;
    repeat (3) tick();

    // READ_LATENCY=3 single read (dut2)
    inst_addr[2] = 32'h30;
    inst_req[2]  = 1'b1;
    push(2, P_INST, mem_init(12), 1'b1);
    for (int t = 0; t < 6; t++) begin
      tick();
      chk1($sformatf("t5_mem_en_%0d", t),  mem_en[2],      t == 0);
      chk1($sformatf("t5_gnt_%0d", t),     inst_gnt[2],    t == 0);
      chk1($sformatf("t5_rvalid_%0d", t),  inst_rvalid[2], t == 4);
      if (t == 0) inst_req[2] = 1'b0;
    end

    // Reset during WAIT abandons the access (dut2)
    inst_addr[2] = 32'h34;
    inst_req[2]  = 1'b1;
    tick();
    chk1("t6_gnt", inst_gnt[2], 1'b1);
    inst_req[2] = 1'b0;
    tick();
    aresetn = 1'b0;
    tick();
    chk_zero(2, "t6_rst");
    aresetn = 1'b1;
    for (int t = 0; t < 6; t++) begin
      tick();
      chk1($sformatf("t6_no_rvalid_%0d", t), inst_rvalid[2], 1'b0);
    end
    inst_addr[2] = 32'h38;
    inst_req[2]  = 1'b1;
    push(2, P_INST, mem_init(14), 1'b1);
    for (int t = 0; t < 6; t++) begin
      tick();
      chk1($sformatf("t6_post_gnt_%0d", t),    inst_gnt[2],    t == 0);
      chk1($sformatf("t6_post_rvalid_%0d", t), inst_rvalid[2], t == 4);
      if (t == 0) inst_req[2] = 1'b0;
    end

    chk32("sb_drained", 32'(sb_q.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
